// File: rtl/lfsr_sync_checker.sv
// Receive-side checker for an LFSR serial stream: self-synchronises a local LFSR,
// then free-runs it and counts bit errors, dropping lock when a window gets too noisy.
module lfsr_sync_checker #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
  parameter int               LOCK_CNT    = 16,
  parameter int               WINDOW      = 64,
  parameter int               LOSS_THRESH = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int               SC_W      = $clog2(WIDTH + 1);
  localparam logic [SC_W-1:0]  SEED_LAST = SC_W'(WIDTH - 1);
  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [15:0]      WIN_LAST  = 16'(WINDOW - 1);
  localparam logic [15:0]      LOSS_LVL  = 16'(LOSS_THRESH);

  typedef enum logic [1:0] {SEED = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t           r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_hist,      w_hist_nxt;
  logic [SC_W-1:0]  r_seed_cnt,  w_seed_cnt_nxt;
  logic [7:0]       r_match_cnt, w_match_cnt_nxt;
  logic [15:0]      r_win_cnt,   w_win_cnt_nxt;
  logic [15:0]      r_win_err,   w_win_err_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic [CNT_W-1:0] r_bit_count, w_bit_count_nxt;
  logic             r_locked,    w_locked_nxt;
  logic             r_bit_err,   w_bit_err_nxt;
  logic             r_lock_lost, w_lock_lost_nxt;
  logic [15:0]      w_win_err_tmp;
  logic             w_pred;
  logic             w_match;
  logic [WIDTH-1:0] w_shift_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_pred     = ^(r_hist & TAPS);
  assign w_match    = (in_bit == w_pred);
  assign w_shift_in = {r_hist[WIDTH-2:0], in_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEED;
      r_hist      <= '0;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_count <= '0;
      r_bit_count <= '0;
      r_locked    <= 1'b0;
      r_bit_err   <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hist      <= w_hist_nxt;
      r_seed_cnt  <= w_seed_cnt_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_win_err   <= w_win_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_bit_count <= w_bit_count_nxt;
      r_locked    <= w_locked_nxt;
      r_bit_err   <= w_bit_err_nxt;
      r_lock_lost <= w_lock_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_hist_nxt      = r_hist;
    w_seed_cnt_nxt  = r_seed_cnt;
    w_match_cnt_nxt = r_match_cnt;
    w_win_cnt_nxt   = r_win_cnt;
    w_win_err_nxt   = r_win_err;
    w_err_count_nxt = r_err_count;
    w_bit_count_nxt = r_bit_count;
    w_bit_err_nxt   = 1'b0;
    w_lock_lost_nxt = 1'b0;
    w_win_err_tmp   = r_win_err;

    if (in_valid) begin
      case (r_state)
        SEED: begin
          w_hist_nxt = w_shift_in;
          if (r_seed_cnt == SEED_LAST) begin
            // An all-zero history is the LFSR lock-up pattern: keep seeding.
            w_seed_cnt_nxt = '0;
            if (w_shift_in != '0) begin
              w_state_nxt     = VERIFY;
              w_match_cnt_nxt = '0;
            end
          end else begin
            w_seed_cnt_nxt = r_seed_cnt + SC_W'(1);
          end
        end
        VERIFY: begin
          w_hist_nxt = w_shift_in;
          if (w_match) begin
            if (r_match_cnt == LOCK_LAST) begin
              w_state_nxt   = LOCKED;
              w_win_cnt_nxt = '0;
              w_win_err_nxt = '0;
            end else begin
              w_match_cnt_nxt = r_match_cnt + 8'd1;
            end
          end else begin
            w_state_nxt    = SEED;
            w_seed_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a received error never enters the history.
          w_hist_nxt      = {r_hist[WIDTH-2:0], w_pred};
          w_bit_count_nxt = sat_inc(r_bit_count);
          if (!w_match) begin
            w_bit_err_nxt   = 1'b1;
            w_err_count_nxt = sat_inc(r_err_count);
            w_win_err_tmp   = r_win_err + 16'd1;
          end
          if (w_win_err_tmp == LOSS_LVL) begin
            w_state_nxt     = SEED;
            w_seed_cnt_nxt  = '0;
            w_lock_lost_nxt = 1'b1;
            w_win_cnt_nxt   = '0;
            w_win_err_nxt   = '0;
          end else if (r_win_cnt == WIN_LAST) begin
            w_win_cnt_nxt = '0;
            w_win_err_nxt = '0;
          end else begin
            w_win_cnt_nxt = r_win_cnt + 16'd1;
            w_win_err_nxt = w_win_err_tmp;
          end
        end
        default: w_state_nxt = SEED;
      endcase
    end

    if (clear_cnt) begin
      w_err_count_nxt = '0;
      w_bit_count_nxt = '0;
    end
    w_locked_nxt = (w_state_nxt == LOCKED);
  end

  assign locked    = r_locked;
  assign bit_err   = r_bit_err;
  assign lock_lost = r_lock_lost;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// Scoreboard bench for lfsr_sync_checker: a behavioural model queues expected
// outputs per driven bit; a monitor pops and compares them after each edge.
module tb_lfsr_sync_checker;
  localparam int         WIDTH       = 8;
  localparam logic [7:0] TAPS        = 8'hB8;
  localparam int         LOCK_CNT    = 16;
  localparam int         WINDOW      = 64;
  localparam int         LOSS_THRESH = 4;
  localparam int         CNT_W       = 16;

  typedef struct packed {
    logic        locked;
    logic        bit_err;
    logic        lock_lost;
    logic [15:0] err;
    logic [15:0] bits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_bit, in_valid, clear_cnt;
  logic        locked, bit_err, lock_lost;
  logic [15:0] err_count, bit_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // behavioural model state (0 seed, 1 verify, 2 locked)
  int         m_st, m_seed, m_match, m_win, m_werr, m_err, m_bits;
  logic [7:0] m_hist;
  logic [7:0] g_state;

  lfsr_sync_checker #(
    .WIDTH(WIDTH), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW),
    .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clear_cnt(clear_cnt),
    .locked(locked), .bit_err(bit_err), .lock_lost(lock_lost),
    .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_seed = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_err = 0; m_bits = 0; m_hist = '0;
  endtask

  task automatic m_step(input logic b, input logic v, input logic c, output exp_t e);
    logic p;
    p = ^(m_hist & TAPS);
    e.bit_err = 1'b0;
    e.lock_lost = 1'b0;
    if (v) begin
      case (m_st)
        0: begin
          m_hist = {m_hist[6:0], b};
          m_seed++;
          if (m_seed == WIDTH) begin
            m_seed = 0;
            if (m_hist != 8'h00) begin m_st = 1; m_match = 0; end
          end
        end
        1: begin
          m_hist = {m_hist[6:0], b};
          if (b == p) begin
            m_match++;
            if (m_match == LOCK_CNT) begin m_st = 2; m_win = 0; m_werr = 0; end
          end else begin
            m_st = 0; m_seed = 0;
          end
        end
        default: begin
          m_hist = {m_hist[6:0], p};
          if (m_bits < 65535) m_bits++;
          if (b != p) begin
            e.bit_err = 1'b1;
            if (m_err < 65535) m_err++;
            m_werr++;
          end
          m_win++;
          if (m_werr == LOSS_THRESH) begin
            m_st = 0; m_seed = 0; e.lock_lost = 1'b1;
          end else if (m_win == WINDOW) begin
            m_win = 0; m_werr = 0;
          end
        end
      endcase
    end
    if (c) begin m_err = 0; m_bits = 0; end
    e.locked = (m_st == 2);
    e.err    = m_err[15:0];
    e.bits   = m_bits[15:0];
  endtask

  task automatic gen_bit(output logic b);
    b = g_state[7];
    g_state = {g_state[6:0], ^(g_state & TAPS)};
  endtask

  task automatic drive(input logic b, input logic v, input logic c);
    exp_t e;
    @(negedge clk);
    in_bit = b; in_valid = v; clear_cnt = c;
    m_step(b, v, c, e);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic stream_bit(input logic inv);
    logic b;
    gen_bit(b);
    drive(b ^ inv, 1'b1, 1'b0);
  endtask

  task automatic wait_lock(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      stream_bit(1'b0);
      if (locked === 1'b1) begin n = i; break; end
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #1;
    in_valid = 1'b0; clear_cnt = 1'b0; rst = 1'b0;
    #1;
    check_val("rst_locked",    32'(locked),    32'd0);
    check_val("rst_bit_err",   32'(bit_err),   32'd0);
    check_val("rst_lock_lost", 32'(lock_lost), 32'd0);
    check_val("rst_err_count", 32'(err_count), 32'd0);
    check_val("rst_bit_count", 32'(bit_count), 32'd0);
    m_reset();
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_val("sb_locked",    32'(locked),    32'(mon_e.locked));
      check_val("sb_bit_err",   32'(bit_err),   32'(mon_e.bit_err));
      check_val("sb_lock_lost", 32'(lock_lost), 32'(mon_e.lock_lost));
      check_val("sb_err_count", 32'(err_count), 32'(mon_e.err));
      check_val("sb_bit_count", 32'(bit_count), 32'(mon_e.bits));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int first, errs, pulse_at, drop, lost_at, nv, lock_c, lock_v;
    logic b;
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; clear_cnt = 1'b0;
    m_reset();
    g_state = 8'h01;
    do_reset();

    // clean stream from seed 8'h01
    first = -1; errs = 0;
    for (int i = 1; i <= 1000; i++) begin
      stream_bit(1'b0);
      if (first < 0 && locked === 1'b1) first = i;
      if (bit_err !== 1'b0) errs++;
    end
    check_val("t1_lock_bits", 32'(first), 32'd24);
    check_val("t1_bit_err_pulses", 32'(errs), 32'd0);
    check_val("t1_bit_count", 32'(bit_count), 32'd976);

    // single inverted bit while locked
    errs = 0; pulse_at = -1; drop = 0;
    for (int i = 1; i <= 200; i++) begin
      stream_bit(i == 100);
      if (bit_err === 1'b1) begin errs++; if (pulse_at < 0) pulse_at = i; end
      if (locked !== 1'b1) drop = 1;
    end
    check_val("t2_pulse_at", 32'(pulse_at), 32'd100);
    check_val("t2_pulses", 32'(errs), 32'd1);
    check_val("t2_err_count", 32'(err_count), 32'd1);
    check_val("t2_lock_drop", 32'(drop), 32'd0);

    // clear coinciding with a counted bit
    gen_bit(b);
    drive(b, 1'b1, 1'b1);
    check_val("clr_err_count", 32'(err_count), 32'd0);
    check_val("clr_bit_count", 32'(bit_count), 32'd0);
    check_val("clr_locked", 32'(locked), 32'd1);

    // four errors in one window -> loss of lock, then re-acquire
    lost_at = -1;
    for (int i = 1; i <= 20; i++) begin
      stream_bit(i >= 10 && i <= 13);
      if (lock_lost === 1'b1) begin lost_at = i; break; end
    end
    check_val("t3_lost_at", 32'(lost_at), 32'd13);
    check_val("t3_locked_after", 32'(locked), 32'd0);
    check_val("t3_err_count", 32'(err_count), 32'd4);
    check_val("t3_bit_count", 32'(bit_count), 32'd13);
    wait_lock(100, first);
    check_val("t3_relock_bits", 32'(first), 32'd24);

    // 3+1 errors straddling a window edge survive; 4th error on a window's last bit loses lock
    lost_at = -1; drop = 0;
    for (int j = 1; j <= 140; j++) begin
      stream_bit((j >= 62 && j <= 65) || (j >= 126 && j <= 128));
      if (lock_lost === 1'b1) begin lost_at = j; break; end
      if (locked !== 1'b1) drop = 1;
    end
    check_val("t3b_lost_at", 32'(lost_at), 32'd128);
    check_val("t3b_early_drop", 32'(drop), 32'd0);
    check_val("t3b_err_count", 32'(err_count), 32'd11);

    // constant zero input never locks
    drop = 0;
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (i > 16 && locked !== 1'b0) drop = 1;
    end
    check_val("t4_zero_locked_seen", 32'(drop), 32'd0);
    check_val("t4_zero_locked", 32'(locked), 32'd0);

    // a mismatch during verify restarts acquisition
    do_reset();
    g_state = 8'h5A;
    first = -1;
    for (int i = 1; i <= 100; i++) begin
      stream_bit(i == 15);
      if (locked === 1'b1) begin first = i; break; end
    end
    check_val("t4b_lock_bits", 32'(first), 32'd39);

    // in_valid alternating 1/0, garbage on idle cycles
    do_reset();
    g_state = 8'h01;
    nv = 0; lock_c = -1; lock_v = -1;
    for (int c = 1; c <= 300; c++) begin
      if (c % 2 == 1) begin
        gen_bit(b);
        nv++;
        drive(b ^ (nv == 60), 1'b1, 1'b0);
      end else begin
        drive(1'($urandom), 1'b0, 1'b0);
      end
      if (lock_c < 0 && locked === 1'b1) begin lock_c = c; lock_v = nv; end
    end
    check_val("t5_lock_valid_bits", 32'(lock_v), 32'd24);
    check_val("t5_lock_cycle", 32'(lock_c), 32'd47);
    check_val("t5_err_count", 32'(err_count), 32'd1);
    check_val("t5_bit_count", 32'(bit_count), 32'd126);
    drive(1'($urandom), 1'b0, 1'b1);
    check_val("t5_clr_err", 32'(err_count), 32'd0);
    check_val("t5_clr_bits", 32'(bit_count), 32'd0);
    check_val("t5_clr_locked", 32'(locked), 32'd1);

    // asynchronous reset mid-lock, then full re-acquisition
    stream_bit(1'b1);
    check_val("t6_pre_err", 32'(err_count), 32'd1);
    do_reset();
    wait_lock(100, first);
    check_val("t6_relock_bits", 32'(first), 32'd24);
    repeat (20) stream_bit(1'b0);
    check_val("t6_bit_count", 32'(bit_count), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_sync_checker.md
Name: lfsr_sync_checker

Overview:
- Receive-side counterpart of the `lfsr` serial generator.
- Samples the 1-bit pseudo-random stream and self-synchronises a local LFSR to it.
- Once locked, compares every incoming bit against the local prediction and counts bit errors.
- Flags loss of lock and re-acquires automatically. Used as the link/BER checker at the far end of the chaotic-LFSR data path.

Parameters:
WIDTH, 8, LFSR length in bits (3..32)
TAPS, 8'hB8, feedback tap mask, WIDTH bits; bit i set means history[i] feeds the XOR
LOCK_CNT, 16, consecutive correct predictions required to declare lock (1..255)
WINDOW, 64, bits per error-monitoring window while locked (2..65535)
LOSS_THRESH, 4, errors within one window that force loss of lock (1..WINDOW)
CNT_W, 16, width of err_count and bit_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_bit  input  1  received serial bit (generator `out`)
in_valid  input  1  in_bit is sampled only when high
clear_cnt  input  1  synchronous clear of err_count and bit_count
locked  output  1  high while in LOCKED
bit_err  output  1  one-cycle pulse: a locked-mode mismatch was sampled
lock_lost  output  1  one-cycle pulse on LOCKED->SEED transition
err_count  output  CNT_W  saturating count of locked-mode errors
bit_count  output  CNT_W  saturating count of bits checked while locked

Behaviour:
Stream convention (generator side, for reference):
- Generator state shifts left; fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}; serial bit = state[WIDTH-1].
- Hence s[n+WIDTH] = ^(history & TAPS), where history holds the last WIDTH received bits, oldest in the MSB.
- Checker keeps `hist` (WIDTH bits) with identical shift convention: new bit enters at bit 0.
- pred = ^(hist & TAPS).

General timing:
- All state advances only on cycles with in_valid=1; in_valid=0 freezes everything except the clear_cnt action.
- All outputs are registered. bit_err and lock_lost are asserted the cycle after the sampling edge of the offending bit.

Reset (rst=0, any time, asynchronous):
- state=SEED; hist=0; all counters 0; locked=0, bit_err=0, lock_lost=0, err_count=0, bit_count=0.
- Reset mid-stream discards all history; re-acquisition starts from scratch.

SEED:
- Shift in_bit into hist; seed counter increments.
- After WIDTH valid bits: if hist != 0, go to VERIFY with match counter = 0.
- If hist == 0 (LFSR lock-up pattern), restart the seed count and stay in SEED.

VERIFY:
- Compare in_bit with pred, then shift in_bit (the received bit) into hist.
- Match: match counter +1; at LOCK_CNT matches go to LOCKED. locked rises the cycle after the LOCK_CNT-th matching bit.
- Mismatch: go to SEED, seed counter = 0. No bit_err and no count change.

LOCKED:
- Local LFSR free-runs: shift pred (not in_bit) into hist, so errors do not propagate.
- Every valid bit: bit_count +1 (saturates at all-ones).
- Mismatch: bit_err pulse, err_count +1 (saturating), window error count +1.
- Window counter counts valid bits 0..WINDOW-1. On the WINDOW-th bit, both the window counter and the window error count clear to 0.
- If the window error count reaches LOSS_THRESH (including on the last bit of a window): go to SEED, locked=0, lock_lost pulse; err_count and bit_count are retained.
- Threshold check takes priority over the window wrap on the same bit.

Counters and clear:
- clear_cnt=1 zeroes err_count and bit_count on the next edge.
- If clear_cnt and a counted bit occur in the same cycle, the clear wins and the result is 0.
- clear_cnt has no effect on lock state.

Test Plan:
- Generator WIDTH=8, TAPS=8'hB8, seed 8'h01, in_valid=1, rst released at cycle 2 -> locked rises exactly 8+16=24 valid bits after reset release, then bit_err stays 0 for 1000 cycles and bit_count=976.
- Same stream with one bit inverted at bit 100 after lock -> exactly one bit_err pulse one cycle later, err_count=1, locked stays 1, and no subsequent mismatches (no error propagation).
- 4 bits inverted within one 64-bit window -> lock_lost pulse on the 4th, locked=0, err_count=4 retained, relock 24 valid bits later. The same 4 errors split as 3 and 1 across a window boundary -> no lock loss.
- Constant in_bit=0 -> remains in SEED indefinitely with locked=0. A single inverted bit during VERIFY -> return to SEED, and lock is delayed by the restart.
- in_valid toggled 1/0 every cycle -> lock after 24 valid bits (48 cycles), with behaviour identical to the continuous case. clear_cnt pulsed while locked -> err_count=0 and bit_count=0, locked unaffected.
- rst driven low mid-LOCKED, asynchronously between clock edges -> all outputs 0 immediately. After release, full re-acquisition takes 24 bits.
